parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 8: number of parking slots; legal range 1..15.
REQ-002 Parameter OPEN_CYCLES, default 4: maximum number of clk cycles the gate stays open while waiting for car_passed.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_entry  input  1  level; a car is present at the entrance sensor.
REQ-006 req_exit  input  1  level; a car is present at the exit sensor.
REQ-007 pass_ok  input  1  level; the entered password is correct.
REQ-008 car_passed  input  1  one-cycle pulse; a car has cleared the gate.
REQ-009 gate_open  output  1  registered; barrier open command.
REQ-010 grant_entry  output  1  registered; the current transaction is an entry.
REQ-011 grant_exit  output  1  registered; the current transaction is an exit.
REQ-012 occupancy  output  4  registered; count of parked cars, range 0..CAPACITY.
REQ-013 full  output  1  registered; asserted when occupancy == CAPACITY.
REQ-014 timeout  output  1  registered one-cycle pulse; the gate closed without car_passed.

Function
REQ-015 The FSM shall have three states: IDLE, AUTH and OPEN. At most one of grant_entry and grant_exit shall be high at any time.
REQ-016 Eligibility: an entry request is eligible when req_entry=1 and full=0. An exit request is eligible when req_exit=1 and occupancy>0.
REQ-017 IDLE, only the entry request eligible: grant_entry<=1 and move to AUTH.
REQ-018 IDLE, only the exit request eligible: grant_exit<=1, gate_open<=1, and move to OPEN.
REQ-019 IDLE, both requests eligible: grant the side opposite to the last_served flag. last_served shall update when each grant is issued.
REQ-020 IDLE, req_entry=1 while full=1: no grant; remain in IDLE.
REQ-021 AUTH, pass_ok=1: gate_open<=1 and move to OPEN.
REQ-022 AUTH, req_entry=0 and pass_ok=0: clear grant_entry and return to IDLE. pass_ok shall take priority if both conditions hold.
REQ-023 OPEN: a wait counter shall clear on entry to OPEN and increment once per cycle.
REQ-024 OPEN, car_passed=1: gate_open<=0, clear the grant, and return to IDLE next cycle. occupancy shall increment for an entry and decrement for an exit.
REQ-025 OPEN, counter reaches OPEN_CYCLES-1 with no car_passed: close the gate, clear the grant, pulse timeout for one cycle, leave occupancy unchanged, and return to IDLE.
REQ-026 car_passed on the same cycle as the final count shall count as a pass; timeout shall not fire.
REQ-027 car_passed outside OPEN shall be ignored.
REQ-028 occupancy shall never exceed CAPACITY and never wrap below 0 (saturate defensively).
REQ-029 full shall update in the same cycle as occupancy.
REQ-030 Latency: a request sampled in IDLE gives a grant one cycle later. pass_ok sampled in AUTH gives gate_open one cycle later.

Reset
REQ-031 While rst=1: state=IDLE, gate_open=0, grant_entry=0, grant_exit=0, occupancy=0, full=0, timeout=0, wait counter=0, last_served=exit.
REQ-032 rst asserted mid-transaction shall close the gate immediately (asynchronously) and discard that transaction's occupancy update.

Verification
REQ-033 Entry: reset, req_entry=1, pass_ok=1 at cycle 2, car_passed at cycle 4 -> grant_entry at cycle 1, gate_open at cycle 3, occupancy=1 and gate_open=0 at cycle 5.
REQ-034 Fill with CAPACITY=2: two complete entries, then req_entry=1 -> full=1, no grant, state remains IDLE.
REQ-035 Simultaneous requests with occupancy=1: req_entry=req_exit=1 held -> grant_entry first. After that transaction completes, grant_exit. Grants alternate thereafter.
REQ-036 Timeout with OPEN_CYCLES=4: exit granted, no car_passed -> gate_open for exactly 4 cycles, one timeout pulse, occupancy unchanged.
REQ-037 Abort and reset: req_entry dropped in AUTH -> IDLE with no gate_open. rst pulsed during OPEN -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: one-barrier car park arbiter for entry/exit requests with password auth and occupancy tracking
//   clk, rst          : clock, asynchronous active-high reset
//   req_entry/req_exit: car waiting at entrance / exit sensor (levels)
//   pass_ok           : entered password is correct (level)
//   car_passed        : one-cycle pulse, car cleared the gate
//   gate_open         : barrier open command
//   grant_entry/exit  : which side owns the current transaction
//   occupancy, full   : parked car count and count == CAPACITY
//   timeout           : one-cycle pulse, gate closed without a car passing
module parking_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_entry,
  input  logic       req_exit,
  input  logic       pass_ok,
  input  logic       car_passed,
  output logic       gate_open,
  output logic       grant_entry,
  output logic       grant_exit,
  output logic [3:0] occupancy,
  output logic       full,
  output logic       timeout
);
  localparam int WW = $clog2(OPEN_CYCLES + 1);
  localparam logic [WW-1:0] LAST = WW'(OPEN_CYCLES - 1);
  localparam logic [3:0] CAP = 4'(CAPACITY);
  typedef enum logic [1:0] {IDLE, AUTH, OPEN} state_t;
  state_t r_state, w_state_n;
  logic [WW-1:0] r_wait, w_wait_n;
  logic [3:0] r_occ, w_occ_n;
  logic r_gate, w_gate_n, r_ge, w_ge_n, r_gx, w_gx_n, r_full, w_full_n, r_to, w_to_n;
  logic r_last_exit, w_last_exit_n;
  logic w_ent_ok, w_ext_ok, w_pick_entry;
  assign w_ent_ok = req_entry && !r_full;
  assign w_ext_ok = req_exit && (r_occ != 4'd0);
  // with both sides eligible, serve the side that did not get the previous grant
  assign w_pick_entry = w_ent_ok && (!w_ext_ok || r_last_exit);
  always_comb begin
    w_state_n = r_state;
    w_wait_n = r_wait;
    w_occ_n = r_occ;
    w_gate_n = r_gate;
    w_ge_n = r_ge;
    w_gx_n = r_gx;
    w_to_n = 1'b0;
    w_last_exit_n = r_last_exit;
    case (r_state)
      IDLE: begin
        if (w_pick_entry) begin
          w_ge_n = 1'b1;
          w_last_exit_n = 1'b0;
          w_state_n = AUTH;
        end else if (w_ext_ok) begin
          w_gx_n = 1'b1;
          w_gate_n = 1'b1;
          w_last_exit_n = 1'b1;
          w_wait_n = '0;
          w_state_n = OPEN;
        end
      end
      AUTH: begin
        if (pass_ok) begin
          w_gate_n = 1'b1;
          w_wait_n = '0;
          w_state_n = OPEN;
        end else if (!req_entry) begin
          w_ge_n = 1'b0;
          w_state_n = IDLE;
        end
      end
      OPEN: begin
        w_wait_n = r_wait + 1'b1;
        if (car_passed || r_wait == LAST) begin
          w_gate_n = 1'b0;
          w_ge_n = 1'b0;
          w_gx_n = 1'b0;
          w_state_n = IDLE;
          w_to_n = !car_passed;
          // count saturates at both ends even though eligibility should prevent it
          if (car_passed && r_ge) w_occ_n = (r_occ >= CAP) ? CAP : r_occ + 4'd1;
          if (car_passed && r_gx) w_occ_n = (r_occ == 4'd0) ? 4'd0 : r_occ - 4'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_full_n = (w_occ_n == CAP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wait <= '0;
      r_occ <= 4'd0;
      r_gate <= 1'b0;
      r_ge <= 1'b0;
      r_gx <= 1'b0;
      r_full <= 1'b0;
      r_to <= 1'b0;
      r_last_exit <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_wait <= w_wait_n;
      r_occ <= w_occ_n;
      r_gate <= w_gate_n;
      r_ge <= w_ge_n;
      r_gx <= w_gx_n;
      r_full <= w_full_n;
      r_to <= w_to_n;
      r_last_exit <= w_last_exit_n;
    end
  end
  assign gate_open = r_gate;
  assign grant_entry = r_ge;
  assign grant_exit = r_gx;
  assign occupancy = r_occ;
  assign full = r_full;
  assign timeout = r_to;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed vector bench for parking_gate_arbiter (CAPACITY=2, OPEN_CYCLES=4)
module tb_parking_gate_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_entry = 1'b0, req_exit = 1'b0, pass_ok = 1'b0, car_passed = 1'b0;
  logic gate_open, grant_entry, grant_exit, full, timeout;
  logic [3:0] occupancy;
  int n_run = 0, n_fail = 0;
  typedef struct packed {
    logic [3:0] in;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];
  parking_gate_arbiter #(.CAPACITY(2), .OPEN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_entry(req_entry), .req_exit(req_exit), .pass_ok(pass_ok),
    .car_passed(car_passed), .gate_open(gate_open), .grant_entry(grant_entry),
    .grant_exit(grant_exit), .occupancy(occupancy), .full(full), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] outs();
    return {gate_open, grant_entry, grant_exit, occupancy, full, timeout};
  endfunction
  task automatic add(input logic [3:0] i, input logic [2:0] g, input int occ, input logic f, input logic t);
    tbl.push_back({i, g, 4'(occ), f, t});
  endtask
  task automatic check(input string name, input logic [8:0] exp);
    n_run++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL %s: got {gate,ge,gx,occ,full,to}=%b_%b_%b_%h_%b_%b expected %b_%b_%b_%h_%b_%b", name,
               gate_open, grant_entry, grant_exit, occupancy, full, timeout,
               exp[8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask
  task automatic step(input logic [3:0] i);
    {req_entry, req_exit, pass_ok, car_passed} = i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // inputs {re,rx,po,cp}; expected {gate,ge,gx}, occupancy, full, timeout
    add(4'b1000, 3'b010, 0, 0, 0);
    add(4'b1000, 3'b010, 0, 0, 0);
    add(4'b1010, 3'b110, 0, 0, 0);
    add(4'b0000, 3'b110, 0, 0, 0);
    add(4'b0001, 3'b000, 1, 0, 0);
    add(4'b1000, 3'b010, 1, 0, 0);
    add(4'b1010, 3'b110, 1, 0, 0);
    add(4'b0001, 3'b000, 2, 1, 0);
    add(4'b1000, 3'b000, 2, 1, 0);
    add(4'b1000, 3'b000, 2, 1, 0);
    add(4'b0100, 3'b101, 2, 1, 0);
    add(4'b0000, 3'b101, 2, 1, 0);
    add(4'b0000, 3'b101, 2, 1, 0);
    add(4'b0000, 3'b101, 2, 1, 0);
    add(4'b0000, 3'b000, 2, 1, 1);
    add(4'b0000, 3'b000, 2, 1, 0);
    add(4'b0100, 3'b101, 2, 1, 0);
    add(4'b0001, 3'b000, 1, 0, 0);
    add(4'b1100, 3'b010, 1, 0, 0);
    add(4'b1110, 3'b110, 1, 0, 0);
    add(4'b1101, 3'b000, 2, 1, 0);
    add(4'b1100, 3'b101, 2, 1, 0);
    add(4'b1101, 3'b000, 1, 0, 0);
    add(4'b1100, 3'b010, 1, 0, 0);
    add(4'b1110, 3'b110, 1, 0, 0);
    add(4'b0000, 3'b110, 1, 0, 0);
    add(4'b0000, 3'b110, 1, 0, 0);
    add(4'b0000, 3'b110, 1, 0, 0);
    add(4'b0000, 3'b000, 1, 0, 1);
    add(4'b1100, 3'b101, 1, 0, 0);
    add(4'b0001, 3'b000, 0, 0, 0);
    add(4'b0001, 3'b000, 0, 0, 0);
    add(4'b0100, 3'b000, 0, 0, 0);
    add(4'b1000, 3'b010, 0, 0, 0);
    add(4'b1010, 3'b110, 0, 0, 0);
    add(4'b0000, 3'b110, 0, 0, 0);
    add(4'b0000, 3'b110, 0, 0, 0);
    add(4'b0000, 3'b110, 0, 0, 0);
    add(4'b0001, 3'b000, 1, 0, 0);
    add(4'b0000, 3'b000, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", 9'd0);
    rst = 1'b0;
    foreach (tbl[k]) begin
      step(tbl[k].in);
      check($sformatf("row%0d", k), tbl[k].exp);
    end
    step(4'b1000);
    check("abort_auth", 9'b010_0001_0_0);
    step(4'b0000);
    check("abort_idle", 9'b000_0001_0_0);
    step(4'b1000);
    step(4'b1010);
    check("pre_rst_open", 9'b110_0001_0_0);
    #3 rst = 1'b1;
    #1 check("rst_async", 9'd0);
    car_passed = 1'b1;
    @(posedge clk);
    #1 check("rst_hold", 9'd0);
    rst = 1'b0;
    step(4'b0000);
    check("post_rst", 9'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
